// File: rtl/arm_alu_seq.sv
// Purpose : sequential ARM-style ALU with internal NZCV status register and iterative multiply.
// Latency : single-cycle ops commit on the Start edge; MUL commits WIDTH cycles after Start.
// Backpr. : Start is only sampled in IDLE; a Start while Busy is dropped, never queued.
//
// Ports:
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   Start, Opcode     operation request (5-bit opcode, ARM data-processing order, 16 = MUL)
//   A, B              operands Rn / Rm
//   S                 flag-update enable for non-test ops
//   ALUSTORE          output enable; Out is high-Z when low
//   Out               registered result (tri-stated)
//   SR                registered flags {N,Z,C,V}
//   Busy              multiply in progress
//   Done              one-cycle completion pulse
module arm_alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       Opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             ALUSTORE,
    output logic [WIDTH-1:0] Out,
    output logic [3:0]       SR,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_sr;
    logic             r_done;

    // Multiply datapath: multiplicand shifts left, multiplier shifts right.
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_mul_s;

    // Single-cycle datapath
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic             w_is_arith;
    logic             w_is_test;
    logic             w_is_mul;
    logic             w_reserved;
    logic [3:0]       w_sr_new;
    logic             w_v;
    logic             w_busy;

    logic [WIDTH-1:0] w_mul_step;
    logic             w_mul_last;

    // ------------------------------------------------------------------
    // Operand selection. Subtract-type ops are folded into x + ~y + cin so
    // the single adder's carry-out is directly ARM's NOT-borrow.
    // ------------------------------------------------------------------
    always_comb begin
        w_x        = '0;
        w_y        = '0;
        w_cin      = 1'b0;
        w_logic    = '0;
        w_is_arith = 1'b0;
        w_is_test  = 1'b0;
        w_is_mul   = 1'b0;
        w_reserved = 1'b0;
        case (Opcode)
            5'd0:  w_logic = A & B;                                         // AND
            5'd1:  w_logic = A ^ B;                                         // EOR
            5'd2:  begin w_is_arith = 1'b1; w_x = A; w_y = ~B; w_cin = 1'b1;    end // SUB
            5'd3:  begin w_is_arith = 1'b1; w_x = B; w_y = ~A; w_cin = 1'b1;    end // RSB
            5'd4:  begin w_is_arith = 1'b1; w_x = A; w_y = B;                   end // ADD
            5'd5:  begin w_is_arith = 1'b1; w_x = A; w_y = B;  w_cin = r_sr[1]; end // ADC
            5'd6:  begin w_is_arith = 1'b1; w_x = A; w_y = ~B; w_cin = r_sr[1]; end // SBC
            5'd7:  begin w_is_arith = 1'b1; w_x = B; w_y = ~A; w_cin = r_sr[1]; end // RSC
            5'd8:  begin w_is_test = 1'b1; w_logic = A & B; end                 // TST
            5'd9:  begin w_is_test = 1'b1; w_logic = A ^ B; end                 // TEQ
            5'd10: begin w_is_test = 1'b1; w_is_arith = 1'b1; w_x = A; w_y = ~B; w_cin = 1'b1; end // CMP
            5'd11: begin w_is_test = 1'b1; w_is_arith = 1'b1; w_x = A; w_y = B; end            // CMN
            5'd12: w_logic = A | B;                                         // ORR
            5'd13: w_logic = B;                                             // MOV
            5'd14: w_logic = A & ~B;                                        // BIC
            5'd15: w_logic = ~B;                                            // MVN
            5'd16: begin
                if (MUL_EN) w_is_mul   = 1'b1;
                else        w_reserved = 1'b1;
            end
            default: w_reserved = 1'b1;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign w_res = w_is_arith ? w_sum[WIDTH-1:0] : w_logic;
    // Overflow: both adder inputs share a sign that differs from the result's.
    assign w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

    always_comb begin
        w_sr_new = r_sr;
        w_sr_new[3] = w_res[WIDTH-1];
        w_sr_new[2] = (w_res == '0);
        if (w_is_arith) begin
            w_sr_new[1] = w_sum[WIDTH];
            w_sr_new[0] = w_v;
        end
    end

    assign w_mul_step = r_acc + (r_mul_b[0] ? r_mul_a : '0);
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (Start && w_is_mul) w_next_state = ST_MUL;
            ST_MUL:  if (w_mul_last)        w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_MUL);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_result <= '0;
            r_sr     <= 4'b0000;
            r_done   <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_s  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        if (w_is_mul) begin
                            r_mul_a <= A;
                            r_mul_b <= B;
                            r_mul_s <= S;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_done <= 1'b1;
                            if (w_reserved)
                                r_result <= '0;
                            else if (!w_is_test)
                                r_result <= w_res;
                            if (w_is_test || (S && !w_reserved))
                                r_sr <= w_sr_new;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc   <= w_mul_step;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= w_mul_step;
                        r_done   <= 1'b1;
                        if (r_mul_s) begin
                            r_sr[3] <= w_mul_step[WIDTH-1];
                            r_sr[2] <= (w_mul_step == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Out  = ALUSTORE ? r_result : {WIDTH{1'bz}};
    assign SR   = r_sr;
    assign Busy = w_busy;
    assign Done = r_done;

endmodule
